// File: rtl/rp2_clock_divider_bank_if.sv
// Byte-wide redbus-style register port for the clock divider bank.
interface rp2_clock_divider_bank_if;
    logic [7:0] Address;
    logic [7:0] Data;
    logic [7:0] ReadData;
    logic       Read;
    logic       Write;
    logic       Enable;

    modport master (output Address, Data, Read, Write, Enable, input ReadData);
    modport slave  (input Address, Data, Read, Write, Enable, output ReadData);
endinterface

// File: rtl/rp2_clock_divider_bank.sv
// Bank of programmable clock-enable dividers with a byte-wide register port.
// Each channel emits a one-cycle Tick and a half-rate Toggle derived from Clock.
module rp2_clock_divider_bank #(
    parameter int unsigned                   CHANNELS  = 2,
    parameter int unsigned                   DIV_WIDTH = 32,
    parameter logic [CHANNELS*DIV_WIDTH-1:0] RESET_DIV = {32'd25000000, 32'd50},
    parameter logic [CHANNELS-1:0]           RESET_EN  = {CHANNELS{1'b1}}
) (
    input  logic                    Clock,
    input  logic                    Reset,
    rp2_clock_divider_bank_if.slave bus,
    input  logic                    SyncRestart,
    output logic [CHANNELS-1:0]     Tick,
    output logic [CHANNELS-1:0]     Toggle,
    output logic [CHANNELS-1:0]     Active
);
    typedef logic [DIV_WIDTH-1:0] divT;
    localparam int unsigned AddrLimit = CHANNELS * 8;

    divT                 divQ     [CHANNELS];
    divT                 divD     [CHANNELS];
    divT                 stageQ   [CHANNELS];
    divT                 stageD   [CHANNELS];
    divT                 counterQ [CHANNELS];
    divT                 counterD [CHANNELS];
    logic [CHANNELS-1:0] enQ, enD, tickQ, tickD, toggleQ, toggleD;
    logic [CHANNELS-1:0] chanHit;
    logic [7:0]          readDataQ, readDataD;
    logic [31:0]         stageWide;
    logic                writeEn, readEn, inRange, commitHit;
    logic [2:0]          offset;

    // A simultaneous write wins over the read, leaving ReadData untouched.
    assign writeEn = bus.Write & bus.Enable;
    assign readEn  = bus.Read & bus.Enable & ~bus.Write;
    assign inRange = 32'(bus.Address) < AddrLimit;
    assign offset  = bus.Address[2:0];

    always_comb begin
        chanHit = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            chanHit[n] = inRange && (bus.Address[7:3] == 5'(n));
        end
    end

    always_comb begin
        readDataD = readDataQ;
        stageWide = '0;
        commitHit = 1'b0;
        if (readEn) readDataD = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            divD[n]     = divQ[n];
            stageD[n]   = stageQ[n];
            counterD[n] = counterQ[n];
            enD[n]      = enQ[n];
            tickD[n]    = 1'b0;
            toggleD[n]  = toggleQ[n];
            commitHit   = writeEn && chanHit[n] && (offset == 3'd5);

            // Widen to 32 bits so byte lanes above DIV_WIDTH drop out naturally.
            stageWide = 32'(stageQ[n]);
            if (writeEn && chanHit[n] && !offset[2]) begin
                stageWide[{offset[1:0], 3'b000} +: 8] = bus.Data;
                stageD[n] = divT'(stageWide);
            end
            if (writeEn && chanHit[n] && (offset == 3'd4)) enD[n] = bus.Data[0];

            if (readEn && chanHit[n]) begin
                if (!offset[2]) begin
                    readDataD = 8'(32'(stageQ[n]) >> {offset[1:0], 3'b000});
                end else if (offset == 3'd4) begin
                    readDataD = {7'b0, enQ[n]};
                end
            end

            if (commitHit) divD[n] = stageQ[n];

            if (SyncRestart || commitHit) begin
                counterD[n] = '0;
                toggleD[n]  = 1'b0;
            end else if (!enQ[n]) begin
                counterD[n] = counterQ[n];
            end else if (divQ[n] == '0) begin
                counterD[n] = '0;
            end else if (counterQ[n] == divQ[n] - divT'(1)) begin
                counterD[n] = '0;
                tickD[n]    = 1'b1;
                toggleD[n]  = ~toggleQ[n];
            end else begin
                counterD[n] = counterQ[n] + divT'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int n = 0; n < CHANNELS; n++) begin
                divQ[n]     <= RESET_DIV[n*DIV_WIDTH +: DIV_WIDTH];
                stageQ[n]   <= RESET_DIV[n*DIV_WIDTH +: DIV_WIDTH];
                counterQ[n] <= '0;
            end
            enQ       <= RESET_EN;
            tickQ     <= '0;
            toggleQ   <= '0;
            readDataQ <= '0;
        end else begin
            divQ      <= divD;
            stageQ    <= stageD;
            counterQ  <= counterD;
            enQ       <= enD;
            tickQ     <= tickD;
            toggleQ   <= toggleD;
            readDataQ <= readDataD;
        end
    end

    assign Tick         = tickQ;
    assign Toggle       = toggleQ;
    assign Active       = enQ;
    assign bus.ReadData = readDataQ;
endmodule

// File: tb/tb_rp2_clock_divider_bank.sv
// Self-checking bench: register table, directed corner sequences and random traffic
// compared against a phase-count model of every channel.
module tb_rp2_clock_divider_bank;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       SyncRestart = 1'b0;
    logic [1:0] Tick, Toggle, Active;

    rp2_clock_divider_bank_if bus ();

    rp2_clock_divider_bank #(
        .CHANNELS  (2),
        .DIV_WIDTH (32),
        .RESET_DIV ({32'd1000, 32'd50}),
        .RESET_EN  (2'b11)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .bus         (bus),
        .SyncRestart (SyncRestart),
        .Tick        (Tick),
        .Toggle      (Toggle),
        .Active      (Active)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         write;
        logic [7:0] expRead;
    } vecT;

    // Model: phase = running cycles since the last restart; everything follows from it.
    longint      phase  [2];
    int unsigned mDiv   [2];
    int unsigned mStage [2];
    bit          mEn    [2];
    bit          mTick  [2];
    logic [7:0]  mRead;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mDiv[0] = 50;   mStage[0] = 50;
        mDiv[1] = 1000; mStage[1] = 1000;
        for (int n = 0; n < 2; n++) begin
            phase[n] = 0;
            mEn[n]   = 1'b1;
            mTick[n] = 1'b0;
        end
        mRead = 8'h00;
    endtask

    function automatic logic [7:0] modelRead(input logic [7:0] a);
        int n, off;
        if (a >= 8'd16) return 8'h00;
        n   = int'(a) / 8;
        off = int'(a) % 8;
        if (off < 4) return 8'((mStage[n] >> (8 * off)) & 32'hFF);
        if (off == 4) return {7'b0, mEn[n]};
        return 8'h00;
    endfunction

    task automatic modelEdge();
        bit we, re, hit, commit;
        int off;
        we  = bus.Write && bus.Enable;
        re  = bus.Read && bus.Enable && !bus.Write;
        off = int'(bus.Address) % 8;
        if (re) mRead = modelRead(bus.Address);
        for (int n = 0; n < 2; n++) begin
            hit      = (bus.Address < 8'd16) && (int'(bus.Address) / 8 == n);
            commit   = we && hit && (off == 5);
            mTick[n] = 1'b0;
            if (SyncRestart || commit) begin
                phase[n] = 0;
            end else if (mEn[n] && mDiv[n] != 0) begin
                phase[n]++;
                mTick[n] = (phase[n] % longint'(mDiv[n])) == 0;
            end
            if (commit) mDiv[n] = mStage[n];
            if (we && hit && off < 4)
                mStage[n] = (mStage[n] & ~(32'hFF << (8 * off))) | (32'(bus.Data) << (8 * off));
            if (we && hit && off == 4) mEn[n] = bus.Data[0];
        end
    endtask

    task automatic compareAll();
        logic [1:0] expTick, expToggle, expActive;
        for (int n = 0; n < 2; n++) begin
            expTick[n]   = mTick[n];
            expActive[n] = mEn[n];
            expToggle[n] = (mDiv[n] == 0) ? 1'b0 : 1'((phase[n] / longint'(mDiv[n])) % 2);
        end
        check("tick", 32'(Tick), 32'(expTick));
        check("toggle", 32'(Toggle), 32'(expToggle));
        check("active", 32'(Active), 32'(expActive));
        check("readdata", 32'(bus.ReadData), 32'(mRead));
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        modelEdge();
        compareAll();
    endtask

    task automatic idle();
        bus.Address = 8'h00;
        bus.Data    = 8'h00;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.Enable  = 1'b0;
    endtask

    task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
        bus.Address = a; bus.Data = d; bus.Write = 1'b1; bus.Read = 1'b0; bus.Enable = 1'b1;
        step();
        idle();
    endtask

    task automatic busRead(input logic [7:0] a);
        bus.Address = a; bus.Data = 8'h00; bus.Write = 1'b0; bus.Read = 1'b1; bus.Enable = 1'b1;
        step();
        idle();
    endtask

    task automatic waitTick(input int ch, input int limit, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (!Tick[ch] && steps < limit);
        if (!Tick[ch]) check("tick_timeout", 32'(steps), 32'(limit + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecT        vecs [21];
        int         t0, t1, first1, n, changes, ticks, r;
        bit         allTick, prev;
        logic [8:0] pat;
        logic [7:0] a;

        vecs = '{
            '{8'h08, 8'h78, 1'b1, 8'h00}, '{8'h09, 8'h56, 1'b1, 8'h00},
            '{8'h0A, 8'h34, 1'b1, 8'h00}, '{8'h0B, 8'h12, 1'b1, 8'h00},
            '{8'h08, 8'h00, 1'b0, 8'h78}, '{8'h09, 8'h00, 1'b0, 8'h56},
            '{8'h0A, 8'h00, 1'b0, 8'h34}, '{8'h0B, 8'h00, 1'b0, 8'h12},
            '{8'h0C, 8'hFF, 1'b1, 8'h00}, '{8'h0C, 8'h00, 1'b0, 8'h01},
            '{8'h0D, 8'h00, 1'b0, 8'h00}, '{8'h0E, 8'h00, 1'b0, 8'h00},
            '{8'h0F, 8'h00, 1'b0, 8'h00}, '{8'hF0, 8'hFF, 1'b1, 8'h00},
            '{8'h00, 8'h00, 1'b0, 8'h32}, '{8'hF0, 8'h00, 1'b0, 8'h00},
            '{8'h0C, 8'h00, 1'b0, 8'h01}, '{8'h10, 8'h00, 1'b0, 8'h00},
            '{8'h0E, 8'hFF, 1'b1, 8'h00}, '{8'h0C, 8'h00, 1'b0, 8'h01},
            '{8'h0E, 8'h00, 1'b0, 8'h00}
        };

        idle();
        modelReset();
        repeat (3) @(posedge Clock);
        #1;
        check("reset_tick", 32'(Tick), 32'h0);
        check("reset_toggle", 32'(Toggle), 32'h0);
        check("reset_active", 32'(Active), 32'h3);
        check("reset_readdata", 32'(bus.ReadData), 32'h0);
        @(negedge Clock);
        Reset = 1'b0;

        // Free run with the reset divisors.
        t0 = 0; t1 = 0; first1 = 0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (Tick[0]) t0++;
            if (Tick[1]) begin
                t1++;
                if (first1 == 0) first1 = i;
            end
        end
        check("ch0_ticks_in_1000", 32'(t0), 32'd20);
        check("ch1_first_tick", 32'(first1), 32'd1000);
        check("ch1_ticks_in_1000", 32'(t1), 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].write) begin
                busWrite(vecs[i].addr, vecs[i].data);
            end else begin
                busRead(vecs[i].addr);
                check("table_read", 32'(bus.ReadData), 32'(vecs[i].expRead));
            end
        end

        // DIV = 3 commit on channel 0.
        busWrite(8'h00, 8'h03); busWrite(8'h01, 8'h00);
        busWrite(8'h02, 8'h00); busWrite(8'h03, 8'h00);
        busWrite(8'h05, 8'hA5);
        check("commit_toggle", 32'(Toggle[0]), 32'h0);
        check("commit_tick", 32'(Tick[0]), 32'h0);
        pat = '0;
        for (int i = 0; i < 9; i++) begin
            step();
            pat[i] = Tick[0];
        end
        check("div3_tick_pattern", 32'(pat), 32'h124);
        busRead(8'h00);
        check("div3_stage_read", 32'(bus.ReadData), 32'h3);

        // DIV = 1: Tick stuck high, Toggle flips every cycle.
        busWrite(8'h00, 8'h01); busWrite(8'h05, 8'h00);
        allTick = 1'b1; changes = 0; prev = Toggle[0];
        for (int i = 0; i < 8; i++) begin
            step();
            allTick &= Tick[0];
            if (Toggle[0] != prev) changes++;
            prev = Toggle[0];
        end
        check("div1_tick_high", 32'(allTick), 32'h1);
        check("div1_toggle_flips", 32'(changes), 32'd8);

        // DIV = 0: channel stopped.
        busWrite(8'h00, 8'h00); busWrite(8'h05, 8'h00);
        ticks = 0; prev = Toggle[0];
        for (int i = 0; i < 20; i++) begin
            step();
            ticks += int'(Tick[0]);
        end
        check("div0_no_ticks", 32'(ticks), 32'd0);
        check("div0_toggle_frozen", 32'(Toggle[0]), 32'(prev));

        // Pause at count 20 of 50, resume, expect the remaining 30 cycles.
        busWrite(8'h00, 8'h32); busWrite(8'h05, 8'h00);
        repeat (19) step();
        busWrite(8'h04, 8'h00);
        check("disable_active", 32'(Active[0]), 32'h0);
        repeat (15) step();
        busWrite(8'h04, 8'h01);
        waitTick(0, 100, n);
        check("reenable_gap", 32'(n), 32'd30);

        // Both channels at DIV 50, ch1 near expiry, then a global restart.
        busWrite(8'h08, 8'h32); busWrite(8'h09, 8'h00);
        busWrite(8'h0A, 8'h00); busWrite(8'h0B, 8'h00);
        busWrite(8'h0D, 8'h00);
        repeat (48) step();
        SyncRestart = 1'b1;
        step();
        SyncRestart = 1'b0;
        check("sync_toggle", 32'(Toggle), 32'h0);
        check("sync_tick", 32'(Tick), 32'h0);
        waitTick(0, 200, n);
        check("sync_gap", 32'(n), 32'd50);
        check("sync_together", 32'(Tick), 32'h3);

        // Read and Write together: write lands, ReadData holds.
        busRead(8'h00);
        check("rw_pre_read", 32'(bus.ReadData), 32'h32);
        bus.Address = 8'h01; bus.Data = 8'h01;
        bus.Read = 1'b1; bus.Write = 1'b1; bus.Enable = 1'b1;
        step();
        idle();
        check("rw_hold", 32'(bus.ReadData), 32'h32);
        busRead(8'h01);
        check("rw_write_landed", 32'(bus.ReadData), 32'h1);
        busWrite(8'h01, 8'h00);

        // Asynchronous reset between clock edges.
        busRead(8'h04);
        step();
        #2;
        Reset = 1'b1;
        #1;
        check("areset_tick", 32'(Tick), 32'h0);
        check("areset_toggle", 32'(Toggle), 32'h0);
        check("areset_readdata", 32'(bus.ReadData), 32'h0);
        check("areset_active", 32'(Active), 32'h3);
        modelReset();
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        busRead(8'h09);
        check("areset_div_restored", 32'(bus.ReadData), 32'h03);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            idle();
            r = int'($urandom_range(0, 99));
            if (r < 30) begin
                a = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) a = 8'($urandom_range(16, 255));
                bus.Address = a;
                if (a[2:0] == 3'd0)      bus.Data = 8'($urandom_range(0, 12));
                else if (!a[2])          bus.Data = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
                else                     bus.Data = 8'($urandom);
                bus.Write  = 1'($urandom_range(0, 1));
                bus.Read   = 1'($urandom_range(0, 1));
                bus.Enable = ($urandom_range(0, 9) != 0);
            end
            SyncRestart = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();
        SyncRestart = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rp2_clock_divider_bank.md
Name: rp2_clock_divider_bank

Overview:
Parametrised bank of programmable clock-enable dividers that replaces the fixed system-clock and cursor-blink divisor counters in the RP2 top level.
- Each channel produces a one-cycle tick strobe and a square-wave toggle output, both derived from the single master Clock.
- Divisors and per-channel enables are programmable at run time over a byte-wide redbus-style register port.
- A global synchronous restart aligns the phase of all channels.

Parameters:
CHANNELS, 2, number of divider channels (1..32)
DIV_WIDTH, 32, divisor and counter width in bits (8..32)
RESET_DIV, {32'd25000000, 32'd50}, packed CHANNELS*DIV_WIDTH reset divisors; channel n uses slice [n*DIV_WIDTH +: DIV_WIDTH]
RESET_EN, {CHANNELS{1'b1}}, per-channel enable value at reset

Ports:
Clock  input  1  master clock; all logic on the rising edge
Reset  input  1  asynchronous, active-high reset
Address  input  8  register byte address
Data  input  8  write data
ReadData  output  8  registered read data
Read  input  1  read strobe, qualified by Enable
Write  input  1  write strobe, qualified by Enable
Enable  input  1  device select (decoded redbus device match)
SyncRestart  input  1  synchronous restart of all channels
Tick  output  CHANNELS  one-cycle strobe per channel at each divisor expiry
Toggle  output  CHANNELS  square wave per channel; inverts at each expiry
Active  output  CHANNELS  current per-channel enable bits

Behaviour:
Reset values:
- Counters = 0; Tick = 0; Toggle = 0; ReadData = 0.
- DIV and STAGE registers = RESET_DIV; CTRL enable bits = RESET_EN.

Register map (channel n at base n*8; bytes little-endian):
- +0..+3: STAGE divisor bytes. Writes affect only the staging register. Bytes above DIV_WIDTH are ignored on write and read as 0.
- +4: CTRL. Bit0 = enable; bits7..1 read as 0.
- +5: COMMIT. Writing any value copies STAGE into DIV and restarts the channel. Reads return 0.
- +6..+7: reserved. Reads return 0; writes are ignored.
- Addresses at or above CHANNELS*8: reads return 0; writes are ignored.

Bus timing:
- A write takes effect on the clock edge where Write & Enable = 1.
- A read is captured on the edge where Read & Enable = 1; ReadData is valid on the following cycle and holds until the next read.
- Read and Write both asserted in the same cycle: the write executes and ReadData is unchanged.
- Reads of +0..+3 return STAGE, not the active DIV.

Counter, per channel, each edge:
- Disabled (enable = 0): counter, Toggle and Tick = 0 all hold. Re-enabling resumes from the held count.
- DIV = 0: channel stopped; counter held at 0, Tick = 0, Toggle holds.
- Enabled and DIV >= 1:
  - If counter == DIV-1: counter <= 0, Tick <= 1, Toggle <= ~Toggle.
  - Otherwise: counter <= counter+1, Tick <= 0.
- Resulting periods: Tick period = DIV cycles; Toggle period = 2*DIV cycles.
- DIV = 1: Tick is high continuously and Toggle inverts every cycle.
- First Tick after restart occurs DIV cycles after the restart edge.

Restart events:
- COMMIT write on channel n: counter <= 0, Toggle <= 0, Tick <= 0 on that edge. The new DIV governs from the next cycle.
- SyncRestart = 1: all channels do counter <= 0, Toggle <= 0, Tick <= 0. SyncRestart takes priority over expiry.
- SyncRestart and a COMMIT in the same cycle: the commit also loads DIV.
- A CTRL write and an expiry in the same cycle: the expiry completes, then the new enable applies from the next edge.

Reset mid-operation: all state returns immediately to reset values, independent of Clock.

Arithmetic: counter compare is DIV_WIDTH-bit unsigned; counters have no overflow beyond DIV-1.

Test Plan:
- Reset, then free-run with defaults -> ch0 Tick every 50 cycles, Toggle period 100; ch1 first Tick at cycle 25000000. Run ch1 with RESET_DIV overridden to 1000 -> Tick every 1000 cycles.
- Write ch0 STAGE = 0x00000003, then COMMIT -> Toggle low on the commit edge, Tick at commit+3, +6, +9; reading +0 returns 0x03 on the next cycle.
- Write STAGE bytes without COMMIT -> output period unchanged. Write DIV = 1 then COMMIT -> Tick constantly 1 and Toggle alternates every cycle. Write DIV = 0 then COMMIT -> no Ticks and Toggle frozen.
- Clear the CTRL enable at count 20 of 50 -> outputs freeze; re-enable -> next Tick arrives exactly 30 cycles later.
- Assert SyncRestart with ch0 mid-count and ch1 near expiry -> both counters 0, Toggles 0, and both Tick together DIV cycles later when DIVs are equal. Assert Read and Write together -> the write lands and ReadData holds its previous value.
- Assert Reset asynchronously mid-period -> all outputs 0 before the next Clock edge. Read address 0xF0 with CHANNELS = 2 -> ReadData 0x00.
